// File: rtl/alu_issue_ctrl.sv
// ALU initiator: issues ADD/SUB/PUSH/POP, owns SP and the condition code.
// Build option: STACK_GUARD_EN enables stack overflow/underflow rejection.
module alu_issue_ctrl #(
  parameter logic [7:0] SP_RESET = 8'hFF,
  parameter logic [7:0] SP_LIMIT = 8'hC0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [1:0] i_req_cmd,
  input  logic [7:0] i_req_a,
  input  logic [7:0] i_req_b,
  output logic [7:0] o_alu_a,
  output logic [7:0] o_alu_b,
  output logic [3:0] o_alu_op,
  input  logic [7:0] i_alu_e,
  input  logic [1:0] i_alu_cc,
  output logic [7:0] o_mem_addr,
  output logic [7:0] o_mem_wdata,
  output logic       o_mem_we,
  output logic       o_mem_re,
  input  logic [7:0] i_mem_rdata,
  input  logic       i_mem_ack,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_err,
  output logic [1:0] o_cc,
  output logic [7:0] o_sp
);

  localparam logic [1:0] CMD_ADD  = 2'd0;
  localparam logic [1:0] CMD_SUB  = 2'd1;
  localparam logic [1:0] CMD_PUSH = 2'd2;
  localparam logic [1:0] CMD_POP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MEM,
    S_RESP
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_cmd;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_sp;
  logic [1:0] r_cc;
  logic [7:0] r_rsp_data;
  logic       r_err;
  logic       w_accept;
  logic       w_guard;

  assign w_accept = i_req_valid && (r_state == S_IDLE);

`ifdef STACK_GUARD_EN
  assign w_guard = ((i_req_cmd == CMD_PUSH) && (r_sp == SP_LIMIT)) ||
                   ((i_req_cmd == CMD_POP)  && (r_sp == SP_RESET));
`else
  assign w_guard = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_guard)                    w_next = S_RESP;
          else if (i_req_cmd == CMD_POP)  w_next = S_MEM;
          else                            w_next = S_EXEC;
        end
      end
      S_EXEC: w_next = (r_cmd == CMD_PUSH) ? S_MEM : S_RESP;
      S_MEM: begin
        if (i_mem_ack)
          w_next = (r_cmd == CMD_POP) ? S_EXEC : S_RESP;
      end
      S_RESP: if (i_rsp_ready) w_next = S_IDLE;
    endcase
  end

  // Strobes decode from state only, so reset drops them asynchronously.
  always_comb begin
    o_alu_a     = '0;
    o_alu_b     = '0;
    o_alu_op    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_we    = 1'b0;
    o_mem_re    = 1'b0;
    unique case (r_state)
      S_EXEC: begin
        o_alu_op = {2'b00, r_cmd};
        if ((r_cmd == CMD_PUSH) || (r_cmd == CMD_POP)) begin
          o_alu_b = r_sp;
        end else begin
          o_alu_a = r_a;
          o_alu_b = r_b;
        end
      end
      S_MEM: begin
        o_mem_addr = r_sp;
        if (r_cmd == CMD_PUSH) begin
          o_mem_we    = 1'b1;
          o_mem_wdata = r_a;
        end else begin
          o_mem_re = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cmd      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_sp       <= SP_RESET;
      r_cc       <= '0;
      r_rsp_data <= '0;
      r_err      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cmd <= i_req_cmd;
            r_a   <= i_req_a;
            r_b   <= i_req_b;
            r_err <= w_guard;
            if (w_guard) r_rsp_data <= '0;
          end
        end
        S_EXEC: begin
          unique case (r_cmd)
            CMD_ADD: r_rsp_data <= i_alu_e;
            CMD_SUB: begin
              r_rsp_data <= i_alu_e;
              r_cc       <= i_alu_cc;
            end
            CMD_PUSH: r_sp <= i_alu_e;
            CMD_POP:  r_sp <= i_alu_e;
          endcase
        end
        S_MEM: begin
          if (i_mem_ack)
            r_rsp_data <= (r_cmd == CMD_PUSH) ? r_a : i_mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready = (r_state == S_IDLE);
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_err;
  assign o_cc        = r_cc;
  assign o_sp        = r_sp;

endmodule
